// File: rtl/alu.sv
// alu: RV32I integer ALU with a one-cycle registered result.
// Optional feature macro ALU_FLAGS_EN adds a registered zero flag output.
module alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUSel,
    output logic [WIDTH-1:0] d_out
`ifdef ALU_FLAGS_EN
    ,
    output logic             zero
`endif
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_SLL  = 4'b0010,
        OP_SLT  = 4'b0011,
        OP_SLTU = 4'b0100,
        OP_XOR  = 4'b0101,
        OP_SRL  = 4'b0110,
        OP_SRA  = 4'b0111,
        OP_OR   = 4'b1000,
        OP_AND  = 4'b1001,
        OP_JALR = 4'b1010,
        OP_LUI  = 4'b1011
    } op_t;

    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   result;
    logic               lt_signed;
    logic               lt_unsigned;

    assign shamt       = B[SHAMT_W-1:0];
    assign sum         = A + B;
    assign lt_signed   = $signed(A) < $signed(B);
    assign lt_unsigned = A < B;

    // Select the operation result; reserved codes yield zero.
    always_comb begin
        result = '0;
        case (op_t'(ALUSel))
            OP_ADD:  result = sum;
            OP_SUB:  result = A - B;
            OP_SLL:  result = A << shamt;
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, lt_signed};
            OP_SLTU: result = {{(WIDTH-1){1'b0}}, lt_unsigned};
            OP_XOR:  result = A ^ B;
            OP_SRL:  result = A >> shamt;
            OP_SRA:  result = $unsigned($signed(A) >>> shamt);
            OP_OR:   result = A | B;
            OP_AND:  result = A & B;
            OP_JALR: result = {sum[WIDTH-1:1], 1'b0};
            OP_LUI:  result = B;
            default: result = '0;
        endcase
    end

    // Register the result every cycle; reset clears it asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            d_out <= '0;
        else
            d_out <= result;
    end

`ifdef ALU_FLAGS_EN
    // Zero flag tracks the registered result, so it resets to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            zero <= 1'b1;
        else
            zero <= (result == '0);
    end
`endif

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed self-checking bench for the registered RV32I ALU.
module tb_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [3:0]  ALUSel = '0;
    logic [31:0] d_out;
`ifdef ALU_FLAGS_EN
    logic        zero;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    alu dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (A),
        .B      (B),
        .ALUSel (ALUSel),
        .d_out  (d_out)
`ifdef ALU_FLAGS_EN
        ,
        .zero   (zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one op, let one rising edge capture it, then check away from the edge.
    task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] sel, input logic [31:0] exp);
        A = a;
        B = b;
        ALUSel = sel;
        @(posedge clk);
        #1;
        check(tag, d_out, exp);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 check("reset_initial", d_out, 32'h0);
`ifdef ALU_FLAGS_EN
        check("reset_zero_flag", {31'b0, zero}, 32'h1);
`endif
        A = 32'h1234;
        B = 32'h1;
        ALUSel = 4'b0000;
        @(posedge clk);
        #1 check("reset_held_over_edge", d_out, 32'h0);
        #2 rst_n = 1'b1;

        step("post_reset_add", 32'd1, 32'd2, 4'b0000, 32'd3);

        step("sweep_add",  32'd1, 32'd2, 4'b0000, 32'd3);
        step("sweep_sub",  32'd1, 32'd2, 4'b0001, 32'hFFFF_FFFF);
        step("sweep_sll",  32'd1, 32'd2, 4'b0010, 32'd4);
        step("sweep_slt",  32'd1, 32'd2, 4'b0011, 32'd1);
        step("sweep_sltu", 32'd1, 32'd2, 4'b0100, 32'd1);
        step("sweep_xor",  32'd1, 32'd2, 4'b0101, 32'd3);
        step("sweep_srl",  32'd1, 32'd2, 4'b0110, 32'd0);
        step("sweep_sra",  32'd1, 32'd2, 4'b0111, 32'd0);
        step("sweep_or",   32'd1, 32'd2, 4'b1000, 32'd3);
        step("sweep_and",  32'd1, 32'd2, 4'b1001, 32'd0);
        step("sweep_jalr", 32'd1, 32'd2, 4'b1010, 32'd2);
        step("sweep_lui",  32'd1, 32'd2, 4'b1011, 32'd2);

        step("slt_min_max",  32'h8000_0000, 32'h7FFF_FFFF, 4'b0011, 32'd1);
        step("sltu_min_max", 32'h8000_0000, 32'h7FFF_FFFF, 4'b0100, 32'd0);
        step("slt_equal",    32'd5, 32'd5, 4'b0011, 32'd0);
        step("sltu_equal",   32'd5, 32'd5, 4'b0100, 32'd0);

        step("sll_31", 32'h8000_0000, 32'h0000_003F, 4'b0010, 32'h0);
        step("srl_31", 32'h8000_0000, 32'h0000_003F, 4'b0110, 32'h1);
        step("sra_31", 32'h8000_0000, 32'h0000_003F, 4'b0111, 32'hFFFF_FFFF);
        step("sll_0",  32'h8000_0000, 32'h0000_0020, 4'b0010, 32'h8000_0000);
        step("srl_0",  32'h8000_0000, 32'h0000_0020, 4'b0110, 32'h8000_0000);
        step("sra_0",  32'h8000_0000, 32'h0000_0020, 4'b0111, 32'h8000_0000);
        step("sra_pos_4", 32'h7000_0000, 32'h0000_0004, 4'b0111, 32'h0700_0000);

        step("add_wrap",   32'hFFFF_FFFF, 32'd1, 4'b0000, 32'h0);
        step("sub_wrap",   32'h0, 32'd1, 4'b0001, 32'hFFFF_FFFF);
        step("jalr_clear", 32'h0000_1001, 32'h0, 4'b1010, 32'h0000_1000);
        step("rsv_1100", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1100, 32'h0);
        step("rsv_1101", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1101, 32'h0);
        step("rsv_1110", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1110, 32'h0);
        step("rsv_1111", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1111, 32'h0);

`ifdef ALU_FLAGS_EN
        step("flag_sub_eq_val", 32'd7, 32'd7, 4'b0001, 32'h0);
        check("flag_sub_eq", {31'b0, zero}, 32'h1);
        step("flag_sub_ne_val", 32'd7, 32'd6, 4'b0001, 32'h1);
        check("flag_sub_ne", {31'b0, zero}, 32'h0);
`endif

        step("pre_async_reset", 32'hDEAD_0000, 32'h0000_BEEF, 4'b1000, 32'hDEAD_BEEF);
        #2 rst_n = 1'b0;
        #1 check("async_reset_midcycle", d_out, 32'h0);
`ifdef ALU_FLAGS_EN
        check("async_reset_zero", {31'b0, zero}, 32'h1);
`endif
        #2 rst_n = 1'b1;
        step("after_async_reset", 32'd10, 32'd3, 4'b0001, 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
